uart_rx_frame_parser: RTL

Sits directly downstream of the UART receiver. It consumes one byte per receive-done strobe and hunts for a sync byte. It then parses a length-prefixed, checksummed frame into an internal payload buffer. Only a frame whose checksum validates is released on a valid/ready byte stream with a last marker; malformed frames are discarded and flagged.

---
 rtl/uart_rx_frame_parser_pkg.sv | 15 +
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_parser.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared definitions for the UART receive frame parser: FSM state encoding
// and the default start-of-frame byte.
package uart_rx_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: 2**AW x 8 register file, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module uart_frame_buf
  import uart_rx_frame_parser_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC/LEN/payload/CSUM frames from a UART byte stream and releases
// only checksum-valid payloads on a valid/ready stream with a last marker.
module uart_rx_frame_parser
  import uart_rx_frame_parser_pkg::*;
#(
  parameter int         BUF_AW = 4,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok_tick,
  output logic       frame_err_tick,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int         MAX_LEN   = 2**BUF_AW;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            r_state, w_state_nx;
  logic [7:0]        r_sum, r_len;
  logic [BUF_AW:0]   r_wcnt;
  logic [BUF_AW-1:0] r_rd_ptr;
  logic              r_ok, r_err, r_ovr;

  logic [7:0] w_rdata, w_len_m1, w_csum_tot;
  logic       w_we, w_ok, w_err, w_drop, w_valid, w_last, w_pay_done;

  assign w_len_m1   = r_len - 8'd1;
  assign w_csum_tot = r_sum + rx_byte;
  assign w_valid    = (r_state == ST_DRAIN);
  assign w_last     = w_valid && ({{(8-BUF_AW){1'b0}}, r_rd_ptr} == w_len_m1);
  assign w_pay_done = ({{(7-BUF_AW){1'b0}}, r_wcnt} == w_len_m1);

  // A SYNC value inside the payload is ordinary data: no resynchronisation.
  always_comb begin
    w_state_nx = r_state;
    w_we       = 1'b0;
    w_ok       = 1'b0;
    w_err      = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (rx_valid && rx_byte == SYNC) w_state_nx = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
            w_state_nx = ST_HUNT;
            w_err      = 1'b1;
          end else begin
            w_state_nx = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          w_we = 1'b1;
          if (w_pay_done) w_state_nx = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (w_csum_tot == 8'd0) begin
            w_state_nx = ST_DRAIN;
            w_ok       = 1'b1;
          end else begin
            w_state_nx = ST_HUNT;
            w_err      = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_drop = rx_valid;
        if (m_ready && w_last) w_state_nx = ST_HUNT;
      end
      default: w_state_nx = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_HUNT;
      r_sum    <= '0;
      r_len    <= '0;
      r_wcnt   <= '0;
      r_rd_ptr <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ok    <= w_ok;
      r_err   <= w_err;
      if (w_drop)           r_ovr <= 1'b1;
      else if (clr_overrun) r_ovr <= 1'b0;
      if (r_state == ST_LEN && w_state_nx == ST_PAYLOAD) begin
        r_len  <= rx_byte;
        r_sum  <= rx_byte;
        r_wcnt <= '0;
      end
      if (w_we) begin
        r_sum  <= r_sum + rx_byte;
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_ok)                                r_rd_ptr <= '0;
      else if (w_valid && m_ready && !w_last)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  uart_frame_buf #(.AW(BUF_AW)) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wcnt[BUF_AW-1:0]),
    .i_wdata (rx_byte),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Gate the buffer so stale or uninitialised contents never reach m_data.
  assign m_data         = w_valid ? w_rdata : 8'd0;
  assign m_valid        = w_valid;
  assign m_last         = w_last;
  assign frame_ok_tick  = r_ok;
  assign frame_err_tick = r_err;
  assign overrun        = r_ovr;

endmodule
